// File: rtl/wc_pkg.sv
// Shared constants and FSM encoding for the Winograd F(4,5) tile scheduler.
package wc_pkg;

  localparam int WC_DW     = 10;
  localparam int WC_TILE   = 8;
  localparam int WC_OUT    = 4;
  localparam int WC_STRIDE = 4;
  localparam int WC_LAT    = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_ISSUE
  } wc_state_t;

endpackage

// File: rtl/wc_res_fifo.sv
// Synchronous result FIFO; head is visible combinationally, push/pop same cycle allowed.
// A push into a full FIFO is taken only when a pop frees the slot in the same cycle.
module wc_res_fifo #(
  parameter int W     = 41,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_cnt;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CW'(DEPTH));
  assign count     = r_cnt;
  assign head_dat  = r_mem[r_rd];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= ptr_inc(r_wr);
      if (w_do_pop)  r_rd <= ptr_inc(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= push_dat;
  end

endmodule

// File: rtl/wc_tile_sched.sv
// Builds stride-4 8-sample tiles for WC, tags them through WC's LAT-cycle pipe and collects results.
// Result appears LAT+1 cycles after the tile edge; issue waits for a FIFO credit so no result is dropped.
module wc_tile_sched
  import wc_pkg::*;
#(
  parameter int DW         = WC_DW,
  parameter int LAT        = WC_LAT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_last,
  output logic [WC_TILE*DW-1:0] wc_d,
  input  logic [WC_OUT*DW-1:0] wc_z,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WC_OUT*DW-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam int TW  = WC_TILE * DW;
  localparam int ZW  = WC_OUT * DW;
  localparam int FW  = ZW + 1;
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam int CW  = $clog2(FIFO_DEPTH + LAT + 2) + 1;

  wc_state_t     r_state;
  logic [TW-1:0] r_win;
  logic [3:0]    r_cnt;
  logic          r_first;
  logic          r_last_pend;
  logic          r_s_ready;
  logic [LAT-1:0] r_tag_vld;
  logic [LAT-1:0] r_tag_last;
  logic [CW-1:0] r_inflight;

  logic          w_accept;
  logic [3:0]    w_need;
  logic [3:0]    w_cnt_inc;
  logic          w_cap;
  logic          w_pop;
  logic          w_issue;
  logic          w_credit;
  logic [CW-1:0] w_used;
  logic [FW-1:0] w_head;
  logic          w_full;
  logic          w_empty;
  logic [FCW-1:0] w_fifo_cnt;

  assign s_ready   = r_s_ready & ~rst;
  assign w_accept  = s_valid & s_ready;
  assign w_need    = r_first ? 4'(WC_TILE) : 4'(WC_STRIDE);
  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_cap     = r_tag_vld[LAT-1];
  assign w_pop     = m_valid & m_ready;

  // Every in-flight tag already owns a FIFO slot, so the FIFO can never overflow.
  assign w_used   = r_inflight + CW'(w_fifo_cnt) - CW'(w_pop);
  assign w_credit = (w_used < CW'(FIFO_DEPTH)) & ~(w_full & ~w_pop);
  assign w_issue  = (r_state == ST_ISSUE) & w_credit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_win       <= '0;
      r_cnt       <= '0;
      r_first     <= 1'b1;
      r_last_pend <= 1'b0;
      r_s_ready   <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_FILL: begin
          if (w_accept) begin
            r_win <= {r_win[TW-DW-1:0], s_data};
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == w_need) begin
              r_state     <= ST_ISSUE;
              r_last_pend <= s_last;
              r_s_ready   <= 1'b0;
            end else if (s_last) begin
              r_state   <= ST_PAD;
              r_s_ready <= 1'b0;
            end else begin
              r_state <= ST_FILL;
            end
          end
        end
        ST_PAD: begin
          r_win <= {r_win[TW-DW-1:0], DW'(0)};
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == w_need) begin
            r_state     <= ST_ISSUE;
            r_last_pend <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (w_credit) begin
            r_cnt     <= '0;
            r_s_ready <= 1'b1;
            if (r_last_pend) begin
              r_win       <= '0;
              r_first     <= 1'b1;
              r_last_pend <= 1'b0;
              r_state     <= ST_IDLE;
            end else begin
              r_first <= 1'b0;
              r_state <= ST_FILL;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tag at stage LAT-1 lines up with the wc_z produced from the tile held during its issue cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_vld  <= '0;
      r_tag_last <= '0;
      r_inflight <= '0;
    end else begin
      r_tag_vld  <= {r_tag_vld[LAT-2:0], w_issue};
      r_tag_last <= {r_tag_last[LAT-2:0], w_issue & r_last_pend};
      case ({w_issue, w_cap})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  wc_res_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_res_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_cap),
    .push_dat ({wc_z, r_tag_last[LAT-1]}),
    .pop      (w_pop),
    .head_dat (w_head),
    .full     (w_full),
    .empty    (w_empty),
    .count    (w_fifo_cnt)
  );

  assign wc_d    = r_win;
  assign m_valid = ~w_empty;
  assign m_data  = w_empty ? '0 : w_head[FW-1:1];
  assign m_last  = ~w_empty & w_head[0];
  assign busy    = (r_state != ST_IDLE) | (r_inflight != '0) | ~w_empty;

endmodule

// File: tb/tb_wc_tile_sched.sv
// Bench for wc_tile_sched: a behavioural WC stand-in drives wc_z, and a scoreboard checks every result.
module tb_wc_tile_sched;

  localparam int DW    = 10;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;
  localparam int TW    = 8 * DW;
  localparam int ZW    = 4 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          m_ready = 1'b0;
  logic          s_ready;
  logic          m_valid;
  logic          m_last;
  logic          busy;
  logic [TW-1:0] wc_d;
  logic [ZW-1:0] wc_z;
  logic [ZW-1:0] m_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_rcv = 0;
  int n_acc = 0;

  logic [ZW:0]   exp_q[$];
  logic [DW-1:0] fb [64];
  int            fn = 0;
  logic [ZW-1:0] wc_pipe [LAT];

  always #5 clk = ~clk;

  wc_tile_sched #(.DW(DW), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .wc_d    (wc_d),
    .wc_z    (wc_z),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .busy    (busy)
  );

  function automatic logic [TW-1:0] pack8(input int v0, v1, v2, v3, v4, v5, v6, v7);
    logic [TW-1:0] t;
    int v [8];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    t = '0;
    for (int i = 0; i < 8; i++) t[TW-1-i*DW -: DW] = DW'(v[i]);
    return t;
  endfunction

  function automatic logic [ZW-1:0] pack4(input int v0, v1, v2, v3);
    logic [ZW-1:0] r;
    int v [4];
    v = '{v0, v1, v2, v3};
    r = '0;
    for (int i = 0; i < 4; i++) r[ZW-1-i*DW -: DW] = DW'(v[i]);
    return r;
  endfunction

  // WC stand-in: the two reference tiles give the reference results, anything else a 5-tap FIR.
  function automatic logic [ZW-1:0] wc_ref(input logic [TW-1:0] t);
    logic [ZW-1:0] r;
    int g [5];
    int acc;
    int d;
    if (t == pack8(2, -10, 3, 4, -13, -18, -16, -28)) return pack4(15, -139, -420, -344);
    if (t == pack8(-19, -6, 3, -9, -12, 11, -4, 0)) return pack4(-223, -277, -63, -49);
    g = '{1, -2, 3, -1, 2};
    r = '0;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int k = 0; k < 5; k++) begin
        d = $signed(t[TW-1-(i+k)*DW -: DW]);
        acc += d * g[k];
      end
      r[ZW-1-i*DW -: DW] = DW'(acc);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    wc_pipe[0] <= wc_ref(wc_d);
    for (int i = 1; i < LAT; i++) wc_pipe[i] <= wc_pipe[i-1];
  end
  assign wc_z = wc_pipe[LAT-1];

  function automatic logic [TW-1:0] tile_of(input int base);
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < 8; i++)
      if (base + i < fn) t[TW-1-i*DW -: DW] = fb[base+i];
    return t;
  endfunction

  task automatic load8(input int v0, v1, v2, v3, v4, v5, v6, v7);
    int v [8];
    v = '{v0, v1, v2, v3, v4, v5, v6, v7};
    fn = 8;
    for (int i = 0; i < 8; i++) fb[i] = DW'(v[i]);
  endtask

  task automatic load_rand(input int n);
    fn = n;
    for (int i = 0; i < n; i++) fb[i] = DW'($urandom);
  endtask

  task automatic send_sample(input logic [DW-1:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        n_acc++;
        return;
      end
    end
    n_cmp++;
    n_err++;
    $display("FAIL send_timeout: s_ready=0 for 2000 cycles, required 1");
  endtask

  task automatic send_frame(input logic expect_out);
    int ntile;
    ntile = (fn <= 8) ? 1 : 1 + (fn - 8 + 3) / 4;
    if (expect_out)
      for (int t = 0; t < ntile; t++)
        exp_q.push_back({wc_ref(tile_of(4 * t)), t == ntile - 1});
    for (int i = 0; i < fn; i++) send_sample(fb[i], i == fn - 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int c = 0; c < bound && exp_q.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", exp_q.size());
    end
  endtask

  task automatic monitor();
    logic [ZW:0] e;
    logic [ZW:0] prev;
    logic        prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_cmp++;
          if ({m_data, m_last} !== prev) begin
            n_err++;
            $display("FAIL hold: {m_data,m_last}=%h changed while stalled, required %h", {m_data, m_last}, prev);
          end
        end
        if (m_valid && m_ready) begin
          n_cmp++;
          n_rcv++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_result: got %h, required no result", {m_data, m_last});
          end else begin
            e = exp_q.pop_front();
            if ({m_data, m_last} !== e) begin
              n_err++;
              $display("FAIL result: {m_data,m_last}=%h, required %h", {m_data, m_last}, e);
            end
          end
        end
        prev_stall = m_valid && !m_ready;
        prev = {m_data, m_last};
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: %b, required 0", s_ready); end
    n_cmp++; if (wc_d !== '0) begin n_err++; $display("FAIL rst_wc_d: %h, required 0", wc_d); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL rst_m_valid: %b, required 0", m_valid); end
    n_cmp++; if (m_data !== '0) begin n_err++; $display("FAIL rst_m_data: %h, required 0", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_err++; $display("FAIL rst_m_last: %b, required 0", m_last); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: %b, required 0", busy); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_s_ready: %b, required 1", s_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: %b, required 0", busy); end
  endtask

  task automatic test_single_frame();
    int lat;
    m_ready = 1'b1;
    load8(2, -10, 3, 4, -13, -18, -16, -28);
    send_frame(1'b1);
    n_cmp++;
    if (wc_d !== pack8(2, -10, 3, 4, -13, -18, -16, -28)) begin
      n_err++; $display("FAIL single_wc_d: %h, required %h", wc_d, pack8(2, -10, 3, 4, -13, -18, -16, -28));
    end
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (m_valid) begin lat = c; break; end
    end
    n_cmp++; if (lat != LAT + 1) begin n_err++; $display("FAIL single_latency: %0d cycles, required %0d", lat, LAT + 1); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: %b, required 1", busy); end
    wait_drain(50);
  endtask

  task automatic test_second_frame();
    int r0;
    r0 = n_rcv;
    n_cmp++; if (wc_d !== '0) begin n_err++; $display("FAIL frame_gap_wc_d: %h, required 0", wc_d); end
    load8(-19, -6, 3, -9, -12, 11, -4, 0);
    send_frame(1'b1);
    wait_drain(50);
    n_cmp++; if (n_rcv - r0 != 1) begin n_err++; $display("FAIL second_count: %0d results, required 1", n_rcv - r0); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL second_idle_busy: %b, required 0", busy); end
  endtask

  task automatic test_stride();
    int r0;
    r0 = n_rcv;
    load_rand(12);
    send_frame(1'b1);
    n_cmp++; if (wc_d !== tile_of(4)) begin n_err++; $display("FAIL stride_wc_d: %h, required %h", wc_d, tile_of(4)); end
    wait_drain(60);
    n_cmp++; if (n_rcv - r0 != 2) begin n_err++; $display("FAIL stride_count: %0d results, required 2", n_rcv - r0); end
  endtask

  task automatic test_pad();
    int r0;
    r0 = n_rcv;
    load_rand(10);
    send_frame(1'b1);
    n_cmp++; if (wc_d !== tile_of(2)) begin n_err++; $display("FAIL pad_wc_d0: %h, required %h", wc_d, tile_of(2)); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL pad_s_ready0: %b, required 0", s_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (wc_d !== tile_of(3)) begin n_err++; $display("FAIL pad_wc_d1: %h, required %h", wc_d, tile_of(3)); end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL pad_s_ready1: %b, required 0", s_ready); end
    @(posedge clk);
    #1;
    n_cmp++; if (wc_d !== tile_of(4)) begin n_err++; $display("FAIL pad_wc_d2: %h, required %h", wc_d, tile_of(4)); end
    wait_drain(60);
    n_cmp++; if (n_rcv - r0 != 2) begin n_err++; $display("FAIL pad_count: %0d results, required 2", n_rcv - r0); end
  endtask

  task automatic test_backpressure();
    int r0;
    int a0;
    r0 = n_rcv;
    a0 = n_acc;
    m_ready = 1'b0;
    load_rand(60);
    fork
      send_frame(1'b1);
      begin
        repeat (200) @(posedge clk);
        #1;
        n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall: s_ready=%b, required 0", s_ready); end
        n_cmp++; if (n_acc - a0 != 40) begin n_err++; $display("FAIL bp_accepted: %0d samples, required 40", n_acc - a0); end
        n_cmp++; if (m_valid !== 1'b1) begin n_err++; $display("FAIL bp_m_valid: %b, required 1", m_valid); end
        m_ready = 1'b1;
      end
    join
    wait_drain(2000);
    n_cmp++; if (n_rcv - r0 != 14) begin n_err++; $display("FAIL bp_count: %0d results, required 14", n_rcv - r0); end
  endtask

  task automatic test_reset_mid();
    int r0;
    m_ready = 1'b1;
    load_rand(5);
    for (int i = 0; i < 5; i++) send_sample(fb[i], 1'b0);
    s_valid = 1'b0;
    rst = 1'b1;
    #2;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL mid_rst_s_ready: %b, required 0", s_ready); end
    n_cmp++; if (wc_d !== '0) begin n_err++; $display("FAIL mid_rst_wc_d: %h, required 0", wc_d); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: %b, required 0", busy); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    // A full frame whose tag is still in flight when reset hits must never surface.
    load_rand(8);
    send_frame(1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_no_result: m_valid=%b, required 0", m_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_idle: busy=%b, required 0", busy); end
    r0 = n_rcv;
    load_rand(8);
    send_frame(1'b1);
    wait_drain(50);
    n_cmp++; if (n_rcv - r0 != 1) begin n_err++; $display("FAIL mid_rst_clean: %0d results, required 1", n_rcv - r0); end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_single_frame();
    test_second_frame();
    test_stride();
    test_pad();
    test_backpressure();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
